regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (wen/wreg/wdata, written on negedge clk) between two writeback requesters: A (ALU result) and B (memory load).
Each requester has a one-entry holding buffer with a valid/ready handshake. Arbitration between the buffers is round-robin, and the port outputs are registered.
Also keeps a 32-bit pending-write scoreboard so the microcontroller can stall reads of registers whose writes are still in flight.

---
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester, scoreboard and regfile write-port bundle
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [AW-1:0]     a_reg;
    logic [DW-1:0]     a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AW-1:0]     b_reg;
    logic [DW-1:0]     b_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_reg;
    logic [2**AW-1:0]  busy;
    logic              o_wen;
    logic [AW-1:0]     o_wreg;
    logic [DW-1:0]     o_wdata;
    logic              o_src_b;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output alloc_en, alloc_reg,
        input  a_ready, b_ready, busy,
        input  o_wen, o_wreg, o_wdata, o_src_b
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  alloc_en, alloc_reg,
        output a_ready, b_ready, busy,
        output o_wen, o_wreg, o_wdata, o_src_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the shared regfile write port with pending-write scoreboard
// Optional same-cycle buffer bypass: define RF_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NR = 2**AW;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t     a_state_q, a_state_d;
    buf_state_t     b_state_q, b_state_d;
    logic [AW-1:0]  a_reg_q, a_reg_d;
    logic [AW-1:0]  b_reg_q, b_reg_d;
    logic [DW-1:0]  a_data_q, a_data_d;
    logic [DW-1:0]  b_data_q, b_data_d;
    logic           ptr_q, ptr_d;
    logic [NR-1:0]  busy_q, busy_d;
    logic           o_wen_q, o_wen_d;
    logic [AW-1:0]  o_wreg_q, o_wreg_d;
    logic [DW-1:0]  o_wdata_q, o_wdata_d;
    logic           o_src_b_q, o_src_b_d;

    logic           a_ready, b_ready;
    logic           a_accept, b_accept;
    logic           grant_a, grant_b;
    logic           byp_a, byp_b;
    logic           win_a, win_b;
    logic [AW-1:0]  win_reg;
    logic [DW-1:0]  win_data;

    // ready depends only on buffer state, never on valid
    assign a_ready  = (a_state_q == EMPTY) && !rst;
    assign b_ready  = (b_state_q == EMPTY) && !rst;
    assign a_accept = bus.a_valid && a_ready;
    assign b_accept = bus.b_valid && b_ready;

    // ptr_q == 0 prefers A, ptr_q == 1 prefers B
    always_comb begin
        grant_a = (a_state_q == FULL) && ((b_state_q != FULL) || !ptr_q);
        grant_b = (b_state_q == FULL) && ((a_state_q != FULL) || ptr_q);
        byp_a   = 1'b0;
        byp_b   = 1'b0;
`ifdef RF_ARB_BYPASS_EN
        if ((a_state_q == EMPTY) && (b_state_q == EMPTY)) begin
            byp_a = a_accept && (!bus.b_valid || !ptr_q);
            byp_b = b_accept && (!bus.a_valid || ptr_q);
        end
`endif
        win_a = grant_a || byp_a;
        win_b = grant_b || byp_b;
    end

    always_comb begin
        win_reg  = '0;
        win_data = '0;
        if (win_b) begin
            win_reg  = byp_b ? bus.b_reg  : b_reg_q;
            win_data = byp_b ? bus.b_data : b_data_q;
        end else if (win_a) begin
            win_reg  = byp_a ? bus.a_reg  : a_reg_q;
            win_data = byp_a ? bus.a_data : a_data_q;
        end
    end

    always_comb begin
        a_state_d = a_state_q;
        a_reg_d   = a_reg_q;
        a_data_d  = a_data_q;
        if (grant_a) begin
            a_state_d = EMPTY;
        end else if (a_accept && !byp_a) begin
            a_state_d = FULL;
            a_reg_d   = bus.a_reg;
            a_data_d  = bus.a_data;
        end
    end

    always_comb begin
        b_state_d = b_state_q;
        b_reg_d   = b_reg_q;
        b_data_d  = b_data_q;
        if (grant_b) begin
            b_state_d = EMPTY;
        end else if (b_accept && !byp_b) begin
            b_state_d = FULL;
            b_reg_d   = bus.b_reg;
            b_data_d  = bus.b_data;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        o_wen_d   = 1'b0;
        o_wreg_d  = o_wreg_q;
        o_wdata_d = o_wdata_q;
        o_src_b_d = o_src_b_q;
        if (win_a) begin
            ptr_d = 1'b1;
        end else if (win_b) begin
            ptr_d = 1'b0;
        end
        // writes to r0 still consume the grant but never strobe the regfile
        if (win_a || win_b) begin
            o_wen_d   = (win_reg != '0);
            o_wreg_d  = win_reg;
            o_wdata_d = win_data;
            o_src_b_d = win_b;
        end
    end

    // set after clear so a same-edge allocation of the retiring register wins
    always_comb begin
        busy_d = busy_q;
        if (win_a || win_b) begin
            busy_d[win_reg] = 1'b0;
        end
        if (bus.alloc_en) begin
            busy_d[bus.alloc_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_state_q <= EMPTY;
            b_state_q <= EMPTY;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            ptr_q     <= 1'b0;
            busy_q    <= '0;
            o_wen_q   <= 1'b0;
            o_wreg_q  <= '0;
            o_wdata_q <= '0;
            o_src_b_q <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            o_wen_q   <= o_wen_d;
            o_wreg_q  <= o_wreg_d;
            o_wdata_q <= o_wdata_d;
            o_src_b_q <= o_src_b_d;
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.busy    = busy_q;
    assign bus.o_wen   = o_wen_q;
    assign bus.o_wreg  = o_wreg_q;
    assign bus.o_wdata = o_wdata_q;
    assign bus.o_src_b = o_src_b_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
`ifdef RF_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_sent;
    int   n_out;
    logic acc;

    regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus_if ();

    regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_single(input logic src, input logic [4:0] r, input logic [31:0] d, input bit chk_busy);
        if (src) begin
            bus_if.b_valid = 1'b1;
            bus_if.b_reg   = r;
            bus_if.b_data  = d;
        end else begin
            bus_if.a_valid = 1'b1;
            bus_if.a_reg   = r;
            bus_if.a_data  = d;
        end
        #1;
        check("ready_idle", src ? bus_if.b_ready : bus_if.a_ready, 1);
        tick();
        bus_if.a_valid = 1'b0;
        bus_if.b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check("single_wen", bus_if.o_wen, (k == LAT-1) && (r != 0));
            if ((k == LAT-1) && (r != 0)) begin
                check("single_wreg", bus_if.o_wreg, r);
                check("single_wdata", bus_if.o_wdata, d);
                check("single_src_b", bus_if.o_src_b, src);
            end
            if (chk_busy) check("single_busy", bus_if.busy[r], k < LAT-1);
        end
        check("ready_after", src ? bus_if.b_ready : bus_if.a_ready, 1);
    endtask

    task automatic contend(input logic [4:0] ra, input logic [31:0] da,
                           input logic [4:0] rb, input logic [31:0] db, input logic first_b);
        logic [4:0]  r1, r2;
        logic [31:0] d1, d2;
        r1 = first_b ? rb : ra;
        d1 = first_b ? db : da;
        r2 = first_b ? ra : rb;
        d2 = first_b ? da : db;
        bus_if.a_valid = 1'b1; bus_if.a_reg = ra; bus_if.a_data = da;
        bus_if.b_valid = 1'b1; bus_if.b_reg = rb; bus_if.b_data = db;
        #1;
        check("cont_a_ready", bus_if.a_ready, 1);
        check("cont_b_ready", bus_if.b_ready, 1);
        tick();
        bus_if.a_valid = 1'b0;
        bus_if.b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check("cont_wen", bus_if.o_wen, (k == LAT-1) || (k == LAT));
            if (k == LAT-1) begin
                check("cont_first_reg", bus_if.o_wreg, r1);
                check("cont_first_data", bus_if.o_wdata, d1);
                check("cont_first_src", bus_if.o_src_b, first_b);
            end
            if (k == LAT) begin
                check("cont_second_reg", bus_if.o_wreg, r2);
                check("cont_second_data", bus_if.o_wdata, d2);
                check("cont_second_src", bus_if.o_src_b, !first_b);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd1; bus_if.a_data = 32'h0;
        bus_if.b_valid = 1'b0; bus_if.b_reg = 5'd0; bus_if.b_data = 32'h0;
        bus_if.alloc_en = 1'b0; bus_if.alloc_reg = 5'd0;

        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_a_ready", bus_if.a_ready, 0);
            check("rst_wen", bus_if.o_wen, 0);
        end
        check("rst_busy", bus_if.busy, 0);
        check("rst_wreg", bus_if.o_wreg, 0);
        check("rst_wdata", bus_if.o_wdata, 0);
        check("rst_src_b", bus_if.o_src_b, 0);
        rst = 1'b0;
        bus_if.a_valid = 1'b0;
        #1;
        check("post_rst_a_ready", bus_if.a_ready, 1);

        bus_if.alloc_en = 1'b1; bus_if.alloc_reg = 5'd5;
        tick();
        bus_if.alloc_en = 1'b0;
        check("alloc_busy5", bus_if.busy[5], 1);
        do_single(1'b0, 5'd5, 32'hDEADBEEF, 1'b1);

        do_single(1'b1, 5'd2, 32'h000000BB, 1'b0);

        contend(5'd3, 32'h11, 5'd7, 32'h22, 1'b0);
        do_single(1'b0, 5'd1, 32'h55, 1'b0);
        contend(5'd3, 32'h33, 5'd7, 32'h44, 1'b1);

        n_sent = 0;
        n_out  = 0;
        bus_if.b_valid = 1'b1;
        bus_if.b_reg   = 5'd9;
        for (int i = 0; i < 12; i++) begin
            bus_if.b_data = 32'h100 + n_sent;
            #1;
            check("bp_b_ready", bus_if.b_ready, (LAT == 1) ? 1'b1 : ((i % 2) == 0));
            acc = bus_if.b_ready;
            tick();
            if (acc) n_sent++;
            if (bus_if.o_wen) begin
                check("bp_wdata", bus_if.o_wdata, 32'h100 + n_out);
                n_out++;
            end
        end
        bus_if.b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.o_wen) begin
                check("bp_wdata_drain", bus_if.o_wdata, 32'h100 + n_out);
                n_out++;
            end
        end
        check("bp_sent", n_sent, (LAT == 1) ? 12 : 6);
        check("bp_out_count", n_out, n_sent);

        bus_if.alloc_en = 1'b1; bus_if.alloc_reg = 5'd0;
        tick();
        bus_if.alloc_en = 1'b0;
        check("alloc_r0_ignored", bus_if.busy, 0);
        do_single(1'b0, 5'd0, 32'hCAFE0000, 1'b0);

        bus_if.alloc_en = 1'b1; bus_if.alloc_reg = 5'd4;
        tick();
        bus_if.alloc_en = 1'b0;
        check("race_busy4_set", bus_if.busy[4], 1);
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd4; bus_if.a_data = 32'h44;
        for (int e = 0; e < LAT; e++) begin
            bus_if.alloc_en  = (e == LAT-1);
            bus_if.alloc_reg = 5'd4;
            tick();
            bus_if.a_valid = 1'b0;
        end
        bus_if.alloc_en = 1'b0;
        check("race_wen", bus_if.o_wen, 1);
        check("race_wreg", bus_if.o_wreg, 4);
        check("race_busy4_kept", bus_if.busy[4], 1);
        tick();
        check("race_busy4_hold", bus_if.busy[4], 1);

        bus_if.alloc_en = 1'b1; bus_if.alloc_reg = 5'd6;
        tick();
        bus_if.alloc_en = 1'b0;
        check("mid_busy6_set", bus_if.busy[6], 1);
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd6; bus_if.a_data = 32'h66;
        tick();
        bus_if.a_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_wen", bus_if.o_wen, 0);
        check("mid_rst_busy", bus_if.busy, 0);
        check("mid_rst_a_ready", bus_if.a_ready, 0);
        rst = 1'b0;
        tick();
        check("mid_post_wen", bus_if.o_wen, 0);
        check("mid_post_a_ready", bus_if.a_ready, 1);
        tick();
        check("mid_post_wen2", bus_if.o_wen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
